// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS-style control unit: opcode
// constants, FSM state encoding, ALU operation codes, operand/PC-source
// select encodings and the DECODE dispatch helper.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    // Dispatch from DECODE; anything not listed is an illegal opcode.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW:    nxt = S_MEM_ADDR;
            OP_R:            nxt = S_EXEC_R;
            OP_ADDI, OP_ORI: nxt = S_EXEC_I;
            OP_BEQ, OP_BNE:  nxt = S_BRANCH;
            OP_J:            nxt = S_JUMP;
            default:         nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on memory and flags the timeout cycle.
//   i_clk       : clock
//   i_reset     : synchronous active-high reset
//   i_waiting   : FSM is in a state that waits on memory
//   i_mem_ready : memory completes the access this cycle
//   o_timeout   : counter has reached MEM_TIMEOUT while still not ready
// -----------------------------------------------------------------------------
module mem_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_waiting,
    input  logic i_mem_ready,
    output logic o_timeout
);

    logic [WAIT_CNT_W-1:0] r_count;
    logic                  w_clear;

    // A ready memory always beats the timeout.
    assign o_timeout = i_waiting & ~i_mem_ready
                     & (r_count == WAIT_CNT_W'(MEM_TIMEOUT));

    // Waiting states can only be left on ready or timeout, so clearing on
    // either (or on not waiting) covers every state change.
    assign w_clear = ~i_waiting | i_mem_ready | o_timeout;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle MIPS subset datapath.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_op                  : opcode, sampled in DECODE only
//   i_zero                : ALU zero flag (used in BRANCH)
//   i_mem_ready           : memory completes current access
//   o_i_or_d              : memory address select (0 PC, 1 ALUOut)
//   o_mem_read/o_mem_write: memory strobes
//   o_ir_write            : instruction register load
//   o_reg_dst, o_mem_to_reg, o_reg_write : register-file controls
//   o_alu_src_a, o_alu_src_b, o_alu_op   : ALU controls
//   o_pc_source, o_pc_en  : PC mux select and load enable
//   o_retire              : last cycle of a completed instruction
//   o_illegal_op, o_mem_fault : one-cycle error pulses
//
// state     | meaning
// ----------+---------------------------------------------------
// FETCH     | read instruction at PC, PC+4 on mem_ready
// DECODE    | sample opcode, precompute branch target
// MEM_ADDR  | compute load/store address
// MEM_READ  | load data access, wait for mem_ready
// MEM_WB    | write load data to register file
// MEM_WRITE | store data access, retires on mem_ready
// EXEC_R    | R-type ALU operation
// EXEC_I    | ADDI/ORI ALU operation
// ALU_WB    | write ALU result to register file
// BRANCH    | compare, conditionally load branch target
// JUMP      | load jump target
// TRAP      | illegal opcode pulse, back to FETCH
// -----------------------------------------------------------------------------
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [5:0]         i_op,
    input  logic               i_zero,
    input  logic               i_mem_ready,
    output logic               o_i_or_d,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_ir_write,
    output logic               o_reg_dst,
    output logic               o_mem_to_reg,
    output logic               o_reg_write,
    output logic               o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic [1:0]         o_pc_source,
    output logic               o_pc_en,
    output logic               o_retire,
    output logic               o_illegal_op,
    output logic               o_mem_fault
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic [2:0] w_alu_op;
    logic       w_waiting;
    logic       w_timeout;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_READ)
                    || (r_state == S_MEM_WRITE);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_waiting   (w_waiting),
        .i_mem_ready (i_mem_ready),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= i_op;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_alu_op     = ALU_ADD;
        o_i_or_d     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_REG;
        o_pc_source  = PC_ALU;
        o_pc_en      = 1'b0;
        o_retire     = 1'b0;
        o_illegal_op = 1'b0;
        o_mem_fault  = 1'b0;

        case (r_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_en    = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH2;
                w_next      = decode_next(i_op);
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                w_next      = (r_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
                if (i_mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                o_mem_write = 1'b1;
                o_i_or_d    = 1'b1;
                if (i_mem_ready) begin
                    o_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_REG;
                w_alu_op    = ALU_RTYPE;
                w_next      = S_ALU_WB;
            end
            S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                w_alu_op    = (r_op == OP_ORI) ? ALU_ORI : ALU_ADDI;
                w_next      = S_ALU_WB;
            end
            S_ALU_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = (r_op == OP_R);
                o_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_REG;
                w_alu_op    = ALU_SUB;
                o_pc_source = PC_ALUOUT;
                o_pc_en     = (r_op == OP_BNE) ? ~i_zero : i_zero;
                o_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                o_pc_source = PC_JUMP;
                o_pc_en     = 1'b1;
                o_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP: begin
                o_illegal_op = 1'b1;
                w_next       = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Timeout only fires with mem_ready low, so strobes are the only
        // active writes left to suppress; i_or_d is left as it was.
        if (w_timeout) begin
            o_mem_fault = 1'b1;
            o_mem_read  = 1'b0;
            o_mem_write = 1'b0;
            w_next      = S_FETCH;
        end

        if (i_reset) begin
            w_next       = S_FETCH;
            w_alu_op     = ALU_ADD;
            o_i_or_d     = 1'b0;
            o_mem_read   = 1'b0;
            o_mem_write  = 1'b0;
            o_ir_write   = 1'b0;
            o_reg_dst    = 1'b0;
            o_mem_to_reg = 1'b0;
            o_reg_write  = 1'b0;
            o_alu_src_a  = 1'b0;
            o_alu_src_b  = SRCB_REG;
            o_pc_source  = PC_ALU;
            o_pc_en      = 1'b0;
            o_retire     = 1'b0;
            o_illegal_op = 1'b0;
            o_mem_fault  = 1'b0;
        end
    end

    // Narrow code zero-extended to the configured width.
    assign o_alu_op = ALUOP_W'(w_alu_op);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [5:0] i_op = 6'h00;
    logic       i_zero = 1'b0;
    logic       i_mem_ready = 1'b0;

    logic       o_i_or_d, o_mem_read, o_mem_write, o_ir_write;
    logic       o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a;
    logic [1:0] o_alu_src_b, o_pc_source;
    logic [2:0] o_alu_op;
    logic       o_pc_en, o_retire, o_illegal_op, o_mem_fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] q_exp[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_op         (i_op),
        .i_zero       (i_zero),
        .i_mem_ready  (i_mem_ready),
        .o_i_or_d     (o_i_or_d),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_ir_write   (o_ir_write),
        .o_reg_dst    (o_reg_dst),
        .o_mem_to_reg (o_mem_to_reg),
        .o_reg_write  (o_reg_write),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_alu_op     (o_alu_op),
        .o_pc_source  (o_pc_source),
        .o_pc_en      (o_pc_en),
        .o_retire     (o_retire),
        .o_illegal_op (o_illegal_op),
        .o_mem_fault  (o_mem_fault)
    );

    wire [18:0] act = {o_i_or_d, o_mem_read, o_mem_write, o_ir_write,
                       o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a,
                       o_alu_src_b, o_alu_op, o_pc_source,
                       o_pc_en, o_retire, o_illegal_op, o_mem_fault};

    // Field order: i_or_d mr mw irw rd m2r rw asa asb aop pcs pce ret ill flt
    function automatic logic [18:0] ov(
        input logic iod, mr, mw, irw, rd, m2r, rw, asa,
        input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] pcs,
        input logic pce, ret, ill, flt);
        return {iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pce, ret, ill, flt};
    endfunction

    function automatic logic [18:0] e_zero();
        return ov(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0);
    endfunction
    function automatic logic [18:0] e_fetch(input logic r);
        return ov(0,1,0,r,0,0,0,0,2'b01,3'b000,2'b00,r,0,0,0);
    endfunction
    function automatic logic [18:0] e_decode();
        return ov(0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,0,0,0);
    endfunction
    function automatic logic [18:0] e_maddr();
        return ov(0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0,0,0);
    endfunction
    function automatic logic [18:0] e_mread();
        return ov(1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0);
    endfunction
    function automatic logic [18:0] e_mwb();
        return ov(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,1,0,0);
    endfunction
    function automatic logic [18:0] e_mwrite(input logic r);
        return ov(1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,r,0,0);
    endfunction
    function automatic logic [18:0] e_mwfault();
        return ov(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,1);
    endfunction
    function automatic logic [18:0] e_execr();
        return ov(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0,0,0);
    endfunction
    function automatic logic [18:0] e_execi(input logic ori);
        return ov(0,0,0,0,0,0,0,1,2'b10,ori ? 3'b101 : 3'b100,2'b00,0,0,0,0);
    endfunction
    function automatic logic [18:0] e_alwb(input logic rt);
        return ov(0,0,0,0,rt,0,1,0,2'b00,3'b000,2'b00,0,1,0,0);
    endfunction
    function automatic logic [18:0] e_branch(input logic p);
        return ov(0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,p,1,0,0);
    endfunction
    function automatic logic [18:0] e_jump();
        return ov(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,1,0,0);
    endfunction
    function automatic logic [18:0] e_trap();
        return ov(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,1,0);
    endfunction

    // One clock cycle: drive inputs after the edge, queue the expected
    // output vector, then pop and compare mid-cycle.
    task automatic cyc(input logic rst, input logic rdy, input logic zf,
                       input logic [5:0] opv, input logic [18:0] exp,
                       input string tag);
        logic [18:0] e;
        string       t;
        @(posedge clk);
        #1;
        i_reset     = rst;
        i_mem_ready = rdy;
        i_zero      = zf;
        i_op        = opv;
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        @(negedge clk);
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        n_checks++;
        assert (act === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, act, e);
        end
    endtask

    initial begin
        // reset: outputs forced low even with mem_ready high
        cyc(1, 1, 0, 6'h00, e_zero(), "reset0");
        cyc(1, 1, 0, 6'h00, e_zero(), "reset1");

        // R-type; op changes after DECODE must not affect reg_dst
        cyc(0, 1, 0, 6'h00, e_fetch(1), "r_fetch");
        cyc(0, 1, 0, 6'h00, e_decode(), "r_decode");
        cyc(0, 1, 0, 6'h2B, e_execr(), "r_exec");
        cyc(0, 1, 0, 6'h2B, e_alwb(1), "r_wb");

        // LW with three wait cycles in MEM_READ
        cyc(0, 1, 0, 6'h23, e_fetch(1), "lw_fetch");
        cyc(0, 1, 0, 6'h23, e_decode(), "lw_decode");
        cyc(0, 1, 0, 6'h23, e_maddr(), "lw_addr");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 6'h23, e_mread(), "lw_wait");
        cyc(0, 1, 0, 6'h23, e_mread(), "lw_read");
        cyc(0, 1, 0, 6'h23, e_mwb(), "lw_wb");

        // BNE taken / not taken, BEQ taken
        cyc(0, 1, 0, 6'h05, e_fetch(1), "bne0_fetch");
        cyc(0, 1, 0, 6'h05, e_decode(), "bne0_decode");
        cyc(0, 1, 0, 6'h05, e_branch(1), "bne_zero0");
        cyc(0, 1, 0, 6'h05, e_fetch(1), "bne1_fetch");
        cyc(0, 1, 0, 6'h05, e_decode(), "bne1_decode");
        cyc(0, 1, 1, 6'h05, e_branch(0), "bne_zero1");
        cyc(0, 1, 0, 6'h04, e_fetch(1), "beq_fetch");
        cyc(0, 1, 0, 6'h04, e_decode(), "beq_decode");
        cyc(0, 1, 1, 6'h04, e_branch(1), "beq_zero1");

        // illegal opcode
        cyc(0, 1, 0, 6'h3F, e_fetch(1), "ill_fetch");
        cyc(0, 1, 0, 6'h3F, e_decode(), "ill_decode");
        cyc(0, 1, 0, 6'h3F, e_trap(), "ill_trap");

        // jump
        cyc(0, 1, 0, 6'h02, e_fetch(1), "j_fetch");
        cyc(0, 1, 0, 6'h02, e_decode(), "j_decode");
        cyc(0, 1, 0, 6'h02, e_jump(), "j_jump");

        // ADDI then ORI
        cyc(0, 1, 0, 6'h08, e_fetch(1), "addi_fetch");
        cyc(0, 1, 0, 6'h08, e_decode(), "addi_decode");
        cyc(0, 1, 0, 6'h08, e_execi(0), "addi_exec");
        cyc(0, 1, 0, 6'h08, e_alwb(0), "addi_wb");
        cyc(0, 1, 0, 6'h0D, e_fetch(1), "ori_fetch");
        cyc(0, 1, 0, 6'h0D, e_decode(), "ori_decode");
        cyc(0, 1, 0, 6'h0D, e_execi(1), "ori_exec");
        cyc(0, 1, 0, 6'h0D, e_alwb(0), "ori_wb");

        // FETCH waiting, then SW that times out
        cyc(0, 0, 0, 6'h2B, e_fetch(0), "fetch_wait0");
        cyc(0, 0, 0, 6'h2B, e_fetch(0), "fetch_wait1");
        cyc(0, 1, 0, 6'h2B, e_fetch(1), "sw_fetch");
        cyc(0, 1, 0, 6'h2B, e_decode(), "sw_decode");
        cyc(0, 1, 0, 6'h2B, e_maddr(), "sw_addr");
        for (int i = 0; i < 15; i++)
            cyc(0, 0, 0, 6'h2B, e_mwrite(0), "sw_wait");
        cyc(0, 0, 0, 6'h2B, e_mwfault(), "sw_timeout");
        cyc(0, 1, 0, 6'h2B, e_fetch(1), "sw_refetch");

        // same SW, mem_ready arrives exactly at the timeout count
        cyc(0, 1, 0, 6'h2B, e_decode(), "sw2_decode");
        cyc(0, 1, 0, 6'h2B, e_maddr(), "sw2_addr");
        for (int i = 0; i < 15; i++)
            cyc(0, 0, 0, 6'h2B, e_mwrite(0), "sw2_wait");
        cyc(0, 1, 0, 6'h2B, e_mwrite(1), "sw2_ready_wins");

        // reset asserted in MEM_WB aborts the load
        cyc(0, 1, 0, 6'h23, e_fetch(1), "rst_fetch");
        cyc(0, 1, 0, 6'h23, e_decode(), "rst_decode");
        cyc(0, 1, 0, 6'h23, e_maddr(), "rst_addr");
        cyc(0, 1, 0, 6'h23, e_mread(), "rst_read");
        cyc(1, 1, 0, 6'h23, e_zero(), "rst_in_wb");
        cyc(0, 1, 0, 6'h23, e_fetch(1), "rst_after");

        n_checks++;
        assert (q_exp.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", q_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 3, width of alu_op (min 3; upper bits zero-extended).
REQ-002 Parameter MEM_TIMEOUT, default 15, max cycles spent waiting on mem_ready before fault (1..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 op  in  6  opcode field of instruction register.
REQ-006 zero  in  1  ALU zero flag, valid in BRANCH state.
REQ-007 mem_ready  in  1  memory completes current access this cycle.
REQ-008 i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut.
REQ-009 mem_read / mem_write  out  1 each  memory strobes.
REQ-010 ir_write  out  1  load instruction register.
REQ-011 reg_dst, mem_to_reg, reg_write  out  1 each  register-file controls.
REQ-012 alu_src_a  out  1 / alu_src_b  out  2  ALU operand selects (b: 00 reg, 01 const 4, 10 imm, 11 imm<<2).
REQ-013 alu_op  out  ALUOP_W  ALU operation code.
REQ-014 pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-015 pc_en  out  1  PC load enable, branch condition resolved internally.
REQ-016 retire  out  1  one-cycle pulse on final cycle of each completed instruction.
REQ-017 illegal_op / mem_fault  out  1 each  one-cycle error pulses.

Function
REQ-018 Supported opcodes: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, ORI 0x0D, LW 0x23, SW 0x2B; all others illegal.
REQ-019 alu_op codes: ADD 000, SUB 001, ADDI 100, ORI 101, RTYPE 111.
REQ-020 Moore FSM; outputs decode from state register, except ir_write, pc_write-derived pc_en and retire also qualified by mem_ready/zero as stated.
REQ-021 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, TRAP.
REQ-022 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00; ir_write and pc_en =1 only when mem_ready; -> DECODE on mem_ready, else stay.
REQ-023 DECODE: alu_src_b=11, alu_op=ADD; next by op: LW/SW->MEM_ADDR, R->EXEC_R, ADDI/ORI->EXEC_I, BEQ/BNE->BRANCH, J->JUMP, illegal->TRAP.
REQ-024 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; LW->MEM_READ, SW->MEM_WRITE.
REQ-025 MEM_READ: mem_read=1, i_or_d=1; -> MEM_WB on mem_ready. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1; -> FETCH.
REQ-026 MEM_WRITE: mem_write=1, i_or_d=1; on mem_ready retire=1, -> FETCH.
REQ-027 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=RTYPE. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADDI or ORI per op. Both -> ALU_WB.
REQ-028 ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type else 0, retire=1; -> FETCH.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01; pc_en=zero for BEQ, ~zero for BNE; retire=1; -> FETCH.
REQ-030 JUMP: pc_source=10, pc_en=1, retire=1; -> FETCH. TRAP: illegal_op=1, no writes, no retire; -> FETCH.
REQ-031 op sampled only in DECODE and held in an internal register for later states; op changes after DECODE have no effect.
REQ-032 Latency with mem_ready always 1: R/ADDI/ORI/SW 4 cycles, LW 5, BEQ/BNE/J 3, illegal 3.
REQ-033 Wait counter (8 bits) increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0, clears on state change or mem_ready.
REQ-034 Counter reaching MEM_TIMEOUT: mem_fault=1 that cycle, counter clears, no register/memory/PC write, -> FETCH (FETCH retries).
REQ-035 mem_ready and timeout in the same cycle: mem_ready wins, no fault.
REQ-036 All unnamed outputs 0 in each state; mem_read and mem_write never both 1.

Reset
REQ-037 reset high: next state FETCH, wait counter 0, latched op 0; during reset cycles all outputs forced 0.
REQ-038 reset mid-instruction aborts it without retire, write or fault pulse.

Structure
REQ-039 Package mips_ctrl_pkg holds opcode constants, state encoding, alu_op codes, alu_src_b/pc_source encodings.
REQ-040 One sub-module: mem_wait_timer (counter, clear, timeout compare).

Verification
REQ-041 op=0x00, mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; alu_op=111, reg_dst=1, retire on cycle 4.
REQ-042 op=0x23, mem_ready low 3 cycles in MEM_READ -> 8 cycles total, mem_to_reg=1 in MEM_WB, no fault.
REQ-043 op=0x05, zero=0 -> pc_en=1 pc_source=01 in BRANCH; zero=1 -> pc_en=0.
REQ-044 op=0x3F -> illegal_op pulse in cycle 3, no reg_write/mem_write, back to FETCH.
REQ-045 op=0x2B, mem_ready held 0, MEM_TIMEOUT=15 -> mem_fault after 15 wait cycles, mem_write drops, FETCH.
REQ-046 reset asserted in MEM_WB -> reg_write 0 that cycle, FETCH next, no retire.
